// File: rtl/uart_frame_arbiter.sv
// uart_frame_arbiter
//   Avalon-MM slave that receives two-byte 8N1 UART frames (data byte, then a
//   check byte equal to data ^ KEY). Each frame is tagged with a status code
//   and queued in a receive FIFO for software. Bytes that software writes are
//   sent out on tx. The block also keeps sticky error flags, a frame timeout
//   and a level interrupt.
//
// Ports
//   clock, resetn      system clock, asynchronous active-low reset
//   address[1:0]       register select (0 data, 1 status/control, 2 irq_en, 3 reserved)
//   chipselect, read,  Avalon-MM slave strobes. readdata is combinational
//   write, writedata   (zero-wait). Side effects happen only with chipselect=1.
//   readdata[31:0]     read data
//   rx                 UART receive pin (asynchronous, synchronised here)
//   tx                 UART transmit pin (idles high)
//   irq                level interrupt, irq_en & (fifo not empty | overflow), registered
//
// Handshake: there is no valid/ready on the bus side. A transfer is the single
// cycle where chipselect & (read | write) is high at the rising clock edge.
// A pop or TX accept takes effect on that edge. read and write must not both
// be high in the same cycle.
module uart_frame_arbiter #(
  parameter int          CLKS_PER_BIT = 5208,
  parameter logic [7:0]  KEY          = 8'h37,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_END   = TO_W'(TO_LIMIT);
  localparam logic [CW-1:0]    DEPTH    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic       {FR_WAIT_DATA, FR_WAIT_CRC}            fr_state_t;

  // ---------------- bus decode ----------------
  logic rd0, wr0, wr1, wr2;
  assign rd0 = chipselect & read  & (address == 2'd0);
  assign wr0 = chipselect & write & (address == 2'd0);
  assign wr1 = chipselect & write & (address == 2'd1);
  assign wr2 = chipselect & write & (address == 2'd2);

  // ---------------- rx synchroniser ----------------
  logic rx_m, rx_s;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             byte_done, frame_err;

  always_comb begin
    rx_next   = rx_state;
    byte_done = 1'b0;
    frame_err = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_s) rx_next = RX_START;
      // A start bit that is gone at half a bit time is a glitch.
      RX_START: if (rx_cnt == HALF_END) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt == BIT_END && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_cnt == BIT_END) begin
                  rx_next   = RX_IDLE;
                  byte_done = rx_s;
                  frame_err = ~rx_s;
                end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      if (rx_state == RX_IDLE || rx_next != rx_state || rx_cnt == BIT_END)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START)
        rx_bit <= '0;
      if (rx_state == RX_DATA && rx_cnt == BIT_END) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
    end
  end

  // ---------------- frame FSM ----------------
  fr_state_t       fr_state, fr_next;
  logic [7:0]      data_byte;
  logic [TO_W-1:0] to_cnt;
  logic            push, crc_ok, timeout_evt;

  assign crc_ok = (rx_shift == (data_byte ^ KEY));

  always_comb begin
    fr_next     = fr_state;
    push        = 1'b0;
    timeout_evt = 1'b0;
    case (fr_state)
      FR_WAIT_DATA: if (byte_done) fr_next = FR_WAIT_CRC;
      FR_WAIT_CRC: begin
        if (byte_done) begin
          push    = 1'b1;
          fr_next = FR_WAIT_DATA;
        end else if (frame_err) begin
          fr_next = FR_WAIT_DATA;
        end else if (to_cnt == TO_END) begin
          timeout_evt = 1'b1;
          fr_next     = FR_WAIT_DATA;
        end
      end
      default: fr_next = FR_WAIT_DATA;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fr_state  <= FR_WAIT_DATA;
      data_byte <= '0;
      to_cnt    <= '0;
    end else begin
      fr_state <= fr_next;
      if (fr_state == FR_WAIT_DATA && byte_done)
        data_byte <= rx_shift;
      // The count only runs while the line is idle: once a start edge is
      // seen it holds until that byte finishes.
      if (fr_state != FR_WAIT_CRC)
        to_cnt <= '0;
      else if (rx_state == RX_IDLE && rx_s && to_cnt != TO_END)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  // ---------------- receive FIFO ----------------
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full, pop, push_ok, flush;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign pop     = rd0 & ~empty;
  assign push_ok = push & (~full | pop);
  assign flush   = wr1 & writedata[4];

  always_ff @(posedge clock) begin
    if (push_ok)
      mem[wr_ptr] <= {(crc_ok ? 2'b01 : 2'b10), data_byte};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t        tx_state, tx_next;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_busy, tx_accept;

  assign tx_busy   = (tx_state != TX_IDLE);
  assign tx_accept = wr0 & ~tx_busy;

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_accept) tx_next = TX_START;
      TX_START: if (tx_cnt == BIT_END) tx_next = TX_DATA;
      TX_DATA:  if (tx_cnt == BIT_END && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_cnt == BIT_END) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE || tx_cnt == BIT_END)
        tx_cnt <= '0;
      else
        tx_cnt <= tx_cnt + 1'b1;
      if (tx_accept) begin
        tx_shift <= writedata[7:0];
        tx_bit   <= '0;
      end else if (tx_state == TX_DATA && tx_cnt == BIT_END) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 1'b1;
      end
    end
  end

  always_comb begin
    case (tx_state)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = tx_shift[0];
      default:  tx = 1'b1;
    endcase
  end

  // ---------------- sticky flags, irq_en, irq ----------------
  // Set has priority over a software clear in the same cycle.
  logic ovf_flag, crc_flag, to_flag, txov_flag, irq_en;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ovf_flag  <= 1'b0;
      crc_flag  <= 1'b0;
      to_flag   <= 1'b0;
      txov_flag <= 1'b0;
      irq_en    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      ovf_flag  <= (push & full & ~pop)            | (ovf_flag  & ~(wr1 & writedata[0]));
      crc_flag  <= frame_err | (push & ~crc_ok)    | (crc_flag  & ~(wr1 & writedata[1]));
      to_flag   <= timeout_evt                     | (to_flag   & ~(wr1 & writedata[2]));
      txov_flag <= (wr0 & tx_busy)                 | (txov_flag & ~(wr1 & writedata[3]));
      if (wr2) irq_en <= writedata[0];
      irq <= irq_en & (~empty | ovf_flag);
    end
  end

  // ---------------- read mux ----------------
  logic [8:0] count_ext;
  assign count_ext = 9'(count);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: if (!empty) readdata = {22'b0, mem[rd_ptr]};
      2'd1: readdata = {16'b0, count_ext[7:0], 1'b0, txov_flag, to_flag,
                        crc_flag, ovf_flag, tx_busy, full, empty};
      2'd2: readdata = {31'b0, irq_en};
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
module tb_uart_frame_arbiter;

  localparam int         CPB   = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] KEY   = 8'h37;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        rx = 1'b1;
  logic        tx;
  logic        irq;

  always #5 clock = ~clock;

  uart_frame_arbiter #(
    .CLKS_PER_BIT(CPB), .KEY(KEY), .FIFO_DEPTH(DEPTH), .TIMEOUT_BITS(20)
  ) dut (
    .clock(clock), .resetn(resetn), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .rx(rx), .tx(tx), .irq(irq)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clock);
    chipselect = 1'b1; read = 1'b1; address = a;
    #1 d = readdata;
    @(posedge clock);
    #1 chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clock);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clock);
    #1 chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic uart_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic uart_byte(input logic [7:0] b);
    @(negedge clock);
    uart_bit(1'b0);
    for (int i = 0; i < 8; i++) uart_bit(b[i]);
    uart_bit(1'b1);
  endtask

  // Expected entry is pushed as the frame is driven; keep=0 for frames that must be lost.
  task automatic send_frame(input logic [7:0] d, input logic [7:0] c, input bit keep);
    logic [1:0] st;
    st = (c == (d ^ KEY)) ? 2'b01 : 2'b10;
    if (keep) exp_q.push_back({22'b0, st, d});
    uart_byte(d);
    uart_byte(c);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] d, e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      bus_read(2'd0, d);
      check(tag, d, e);
    end
  endtask

  task automatic status_check(input string tag, input logic [31:0] e);
    logic [31:0] d;
    bus_read(2'd1, d);
    check(tag, d, e);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic [7:0]  txb;

  initial begin
    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock) resetn = 1'b1;
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);
    status_check("rst_status", 32'h1);
    bus_read(2'd0, rd); check("rst_empty_read", rd, 32'h0);
    bus_read(2'd2, rd); check("rst_irq_en", rd, 32'h0);
    bus_read(2'd3, rd); check("addr3_read", rd, 32'h0);

    // reset during RX of byte 2 and during TX
    uart_byte(8'h11);
    bus_write(2'd0, 32'h00);
    @(negedge clock);
    uart_bit(1'b0); uart_bit(1'b1); uart_bit(1'b0);
    check("mid_tx_low", {31'b0, tx}, 32'd0);
    status_check("mid_status", 32'h5);
    @(negedge clock) resetn = 1'b0;
    #1 check("midrst_tx", {31'b0, tx}, 32'd1);
    rx = 1'b1;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    status_check("midrst_status", 32'h1);
    repeat (100) @(negedge clock);
    status_check("midrst_no_entry", 32'h1);
    check("midrst_irq", {31'b0, irq}, 32'd0);

    // valid frame
    send_frame(8'hA5, 8'h92, 1'b1);
    status_check("valid_count1", 32'h0000_0100);
    pop_check("valid_entry");
    status_check("valid_after_pop", 32'h1);

    // bad check byte
    send_frame(8'h10, 8'h00, 1'b1);
    pop_check("badcrc_entry");
    status_check("badcrc_sticky", 32'h11);
    bus_write(2'd1, 32'h2);
    status_check("badcrc_clear", 32'h1);

    // flush
    send_frame(8'h3A, 8'h3A ^ KEY, 1'b1);
    bus_write(2'd1, 32'h10);
    exp_q.delete();
    status_check("flush_status", 32'h1);

    // overflow with irq enabled
    bus_write(2'd2, 32'h1);
    for (int k = 0; k < 5; k++) begin
      txb = 8'($urandom_range(0, 255));
      send_frame(txb, txb ^ KEY, k < DEPTH);
    end
    status_check("ovf_status", 32'h0000_040A);
    check("ovf_irq", {31'b0, irq}, 32'd1);
    for (int k = 0; k < DEPTH; k++) pop_check($sformatf("ovf_entry%0d", k));
    status_check("ovf_drained", 32'h9);
    check("ovf_irq_held", {31'b0, irq}, 32'd1);
    bus_write(2'd1, 32'h1);
    repeat (2) @(negedge clock);
    check("ovf_irq_clear", {31'b0, irq}, 32'd0);
    status_check("ovf_cleared", 32'h1);
    bus_read(2'd2, rd); check("irq_en_read", rd, 32'h1);
    bus_write(2'd2, 32'h0);

    // timeout
    uart_byte(8'h55);
    repeat (20 * CPB + CPB) @(negedge clock);
    status_check("timeout_sticky", 32'h21);
    send_frame(8'h01, 8'h36, 1'b1);
    pop_check("timeout_next_frame");
    bus_write(2'd1, 32'h4);
    status_check("timeout_clear", 32'h1);

    // TX and overrun
    txb = 8'h3C;
    bus_write(2'd0, {24'b0, txb});
    fork
      begin
        repeat (CPB / 2) @(negedge clock);
        check("tx_start", {31'b0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          check($sformatf("tx_bit%0d", i), {31'b0, tx}, {31'b0, txb[i]});
        end
        repeat (CPB) @(negedge clock);
        check("tx_stop", {31'b0, tx}, 32'd1);
      end
      begin
        repeat (20) @(negedge clock);
        bus_write(2'd0, 32'hC3);
      end
    join
    for (int i = 0; i < 4; i++) begin
      repeat (CPB) @(negedge clock);
      check($sformatf("tx_idle%0d", i), {31'b0, tx}, 32'd1);
    end
    status_check("tx_overrun", 32'h41);
    bus_write(2'd1, 32'h8);
    status_check("tx_overrun_clear", 32'h1);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_frame_arbiter.md
Name: uart_frame_arbiter

Overview:
- Avalon-MM slave that receives 8N1 UART frames of two bytes, data then CRC byte.
- Validates each frame against a key, tags it with a status code and queues it in a receive FIFO for software.
- Also transmits software-written bytes over UART TX, and adds sticky error flags, a frame timeout and an interrupt.
- Sits between the sensor bus pins (rx/tx) and the processor interconnect.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud); minimum 4
KEY, 8'h37, checksum key; frame valid iff crc_byte == data_byte ^ KEY
FIFO_DEPTH, 16, receive FIFO entries; power of two, 2..256
TIMEOUT_BITS, 20, bit-times allowed between end of data byte and start bit of CRC byte

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
address  in  2  register select
chipselect  in  1  slave select
read  in  1  read strobe
write  in  1  write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational, zero-wait
rx  in  1  UART receive pin
tx  out  1  UART transmit pin
irq  out  1  interrupt, level, active-high

Behaviour:
- Reset: asynchronous assert on resetn=0, synchronous release. Reset values: tx=1, irq=0, FIFO empty, stickies=0, irq_en=0, RX/TX/frame FSMs idle. Reset mid-frame or mid-transmit aborts it with no FIFO push.
- rx passes a 2-flop synchroniser.
- RX FSM: IDLE -> START on rx=0 -> verify rx=0 at CLKS_PER_BIT/2, else back to IDLE (glitch) -> DATA samples 8 bits LSB-first at bit centres -> STOP samples stop bit.
  - Stop=0: framing error. Byte is discarded, crc sticky is set, frame FSM returns to WAIT_DATA.
  - Otherwise a 1-cycle byte_done pulse is produced.
- Frame FSM:
  - WAIT_DATA: byte_done latches data_byte -> WAIT_CRC and starts the timeout counter.
  - WAIT_CRC: byte_done compares crc_byte with data_byte^KEY and pushes entry {status, data_byte} -> WAIT_DATA.
    - status 2'b01 = valid. status 2'b10 = CRC mismatch; entry is still pushed and crc sticky is set.
  - Timeout: counter reaches TIMEOUT_BITS*CLKS_PER_BIT with no new start bit -> discard data_byte, set timeout sticky -> WAIT_DATA. A detected start edge freezes the counter.
- FIFO:
  - A push while full is dropped and sets overflow sticky, unless a pop occurs in the same cycle; then both take effect and count is unchanged.
  - Push and pop in the same cycle when not empty/full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count range is 0..FIFO_DEPTH.
- Register map (readdata bits not listed = 0):
  - addr0 read: head entry, [7:0] data, [9:8] status; if empty, returns 0 (status 00). chipselect&read pops on the clock edge when not empty; a read while empty has no effect.
  - addr0 write: writedata[7:0] to TX. Accepted only if TX idle; if busy, the byte is dropped and tx_overrun sticky is set.
  - addr1 read (status): [0] empty, [1] full, [2] tx_busy, [3] overflow, [4] crc_err, [5] timeout, [6] tx_overrun, [15:8] count (0-extended / truncated to 8 bits; count=256 reads 0 with full=1).
  - addr1 write (control, write-1 actions): [0] clear overflow, [1] clear crc_err, [2] clear timeout, [3] clear tx_overrun, [4] flush FIFO. A set event in the same cycle as a clear wins (flag stays 1). Flush in the same cycle as a push leaves FIFO empty.
  - addr2 read/write: [0] irq_en. Read returns {31'b0, irq_en}.
  - addr3: reads 0, writes ignored.
- irq is registered: irq = irq_en & (~empty | overflow). It updates one cycle after the cause.
- TX FSM: IDLE -> START (1 bit time) -> 8 data bits LSB-first -> STOP (1 bit time) -> IDLE. tx_busy is 1 from the accepting edge until return to IDLE.
- Reads and writes have no side effects unless chipselect=1. Simultaneous read and write is not permitted (undefined).

Test Plan:
- Reset mid-activity (CLKS_PER_BIT=8 for all tests): assert resetn=0 during RX of byte 2 and during TX -> tx=1 immediately, status reads 0x00000001, no entry, irq=0.
- Valid frame: send 0xA5 then 0x92 (0xA5^0x37) -> addr0 reads 0x000001A5 and pops; status then reads empty=1, count=0.
- Bad CRC: send 0x10, 0x00 -> addr0 reads 0x00000210; status bit4=1; write addr1 0x2 -> bit4=0.
- Overflow (FIFO_DEPTH=4): push 5 valid frames -> count=4, full=1, overflow=1. With irq_en=1, irq=1. Reads return frames 1..4 in order; frame 5 is lost.
- Timeout: send 0x55, then idle 20*8+8 cycles -> no entry, timeout=1. A subsequent frame 0x01/0x36 is received normally.
- TX and overrun: write addr0 0x3C -> tx shows start, bits 0,0,1,1,1,1,0,0, stop at 8-cycle spacing. A second write during the frame sets tx_overrun, and tx shows only the first byte.
